// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch core.
// State encoding matches the 2-bit state output seen by the display logic.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_NINE = 4'h9;
    localparam logic [3:0] BCD_ZERO = 4'h0;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_NINE) ? BCD_NINE : d;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_core_digit.sv
// One combinational BCD digit step; co is carry (up) or borrow (down).
// Digits are chained so that en of digit k is co of digit k-1.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic [3:0] d,
    input  logic       en,
    input  logic       dn,
    output logic [3:0] q,
    output logic       co
);

    always_comb begin
        q  = d;
        co = 1'b0;
        if (en) begin
            if (!dn) begin
                if (d >= BCD_NINE) begin
                    q  = BCD_ZERO;
                    co = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == BCD_ZERO) begin
                    q  = BCD_NINE;
                    co = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// N-digit BCD up/down stopwatch engine with run/pause/done control,
// preload with digit clamping, lap capture and optional wrap-around.
module bcd_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int NDIG = 4,
    parameter bit WRAP = 1'b0
) (
    input  logic              c_clk,
    input  logic              C_clr,
    input  logic              tick,
    input  logic              go,
    input  logic              rst_cnt,
    input  logic              lap,
    input  logic              dir,
    input  logic              use_load,
    input  logic [4*NDIG-1:0] load,
    output logic [4*NDIG-1:0] count,
    output logic [4*NDIG-1:0] lap_count,
    output logic              lap_valid,
    output logic [1:0]        state,
    output logic              done,
    output logic              wrap_p
);

    localparam int W = 4 * NDIG;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   lap_q, lap_d;
    logic           lvld_q, lvld_d;
    logic           dir_q, dir_d;
    logic           done_q, done_d;
    logic           wrap_q, wrap_d;

    logic [W-1:0]   start_val;
    logic [W-1:0]   term_idle;
    logic [W-1:0]   term_run;
    logic [W-1:0]   step_val;
    logic [NDIG:0]  carry;

    // Start/terminal values: idle uses the live dir, run uses the latch.
    always_comb begin
        for (int k = 0; k < NDIG; k++) begin
            start_val[4*k +: 4] = use_load ? bcd_clamp(load[4*k +: 4])
                                           : (dir ? BCD_NINE : BCD_ZERO);
            term_idle[4*k +: 4] = dir   ? BCD_ZERO : BCD_NINE;
            term_run[4*k +: 4]  = dir_q ? BCD_ZERO : BCD_NINE;
        end
    end

    assign carry[0] = tick;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_digit u_dig (
            .d  (count_q[4*g +: 4]),
            .en (carry[g]),
            .dn (dir_q),
            .q  (step_val[4*g +: 4]),
            .co (carry[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lap_d   = lap_q;
        lvld_d  = lvld_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        if (rst_cnt) begin
            state_d = ST_IDLE;
            count_d = start_val;
            lvld_d  = 1'b0;
            dir_d   = dir;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    count_d = start_val;
                    dir_d   = dir;
                    if (go) begin
                        if (!WRAP && (start_val == term_idle))
                            state_d = ST_DONE;
                        else
                            state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        count_d = step_val;
                        wrap_d  = WRAP && carry[NDIG];
                    end
                    if (go)
                        state_d = ST_PAUSE;
                    if (!WRAP && tick && (step_val == term_run))
                        state_d = ST_DONE;
                    if (lap) begin
                        lap_d  = count_d;
                        lvld_d = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (go)
                        state_d = ST_RUN;
                    if (lap) begin
                        lap_d  = count_q;
                        lvld_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge c_clk or posedge C_clr) begin
        if (C_clr) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            lap_q   <= '0;
            lvld_q  <= 1'b0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lap_q   <= lap_d;
            lvld_q  <= lvld_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count     = count_q;
    assign lap_count = lap_q;
    assign lap_valid = lvld_q;
    assign state     = state_q;
    assign done      = done_q;
    assign wrap_p    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Directed bench for bcd_stopwatch_core: a stop-at-terminal and a
// wrapping instance share stimulus; expectations go through a queue.
module tb_bcd_stopwatch_core;

    logic        c_clk = 1'b0;
    logic        C_clr = 1'b1;
    logic        tick = 1'b0, go = 1'b0, rst_cnt = 1'b0, lap = 1'b0;
    logic        dir = 1'b0, use_load = 1'b0;
    logic [15:0] load = 16'h0;

    logic [15:0] cnt0, lcnt0, cnt1, lcnt1;
    logic        lv0, dn0, wp0, lv1, dn1, wp1;
    logic [1:0]  st0, st1;

    int n_eval = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        int          inst;
        int          sig;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    bcd_stopwatch_core #(.NDIG(4), .WRAP(1'b0)) u0 (
        .c_clk(c_clk), .C_clr(C_clr), .tick(tick), .go(go),
        .rst_cnt(rst_cnt), .lap(lap), .dir(dir), .use_load(use_load),
        .load(load), .count(cnt0), .lap_count(lcnt0), .lap_valid(lv0),
        .state(st0), .done(dn0), .wrap_p(wp0)
    );

    bcd_stopwatch_core #(.NDIG(4), .WRAP(1'b1)) u1 (
        .c_clk(c_clk), .C_clr(C_clr), .tick(tick), .go(go),
        .rst_cnt(rst_cnt), .lap(lap), .dir(dir), .use_load(use_load),
        .load(load), .count(cnt1), .lap_count(lcnt1), .lap_valid(lv1),
        .state(st1), .done(dn1), .wrap_p(wp1)
    );

    initial forever #5 c_clk = ~c_clk;

    // sig: 0 count, 1 lap_count, 2 lap_valid, 3 state, 4 done, 5 wrap_p
    function automatic logic [15:0] obs(input int inst, input int sig);
        logic [15:0] r;
        r = 16'h0;
        case (sig)
            0: r = inst ? cnt1 : cnt0;
            1: r = inst ? lcnt1 : lcnt0;
            2: r = {15'h0, inst ? lv1 : lv0};
            3: r = {14'h0, inst ? st1 : st0};
            4: r = {15'h0, inst ? dn1 : dn0};
            default: r = {15'h0, inst ? wp1 : wp0};
        endcase
        return r;
    endfunction

    task automatic expect_v(input string tag, input int inst,
                            input int sig, input logic [15:0] v);
        exp_t e;
        e.tag = tag; e.inst = inst; e.sig = sig; e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        logic [15:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.inst, e.sig);
            n_eval++;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s (u%0d): got %h expected %h",
                       e.tag, e.inst, o, e.val);
            end
        end
    endtask

    task automatic cyc(input bit t, input bit g, input bit l, input bit r);
        tick = t; go = g; lap = l; rst_cnt = r;
        @(posedge c_clk);
        #1;
        tick = 0; go = 0; lap = 0; rst_cnt = 0;
        chk();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    initial begin
        // reset values
        repeat (2) @(posedge c_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            expect_v("rst_count", i, 0, 16'h0);
            expect_v("rst_lap", i, 1, 16'h0);
            expect_v("rst_lvld", i, 2, 16'h0);
            expect_v("rst_state", i, 3, 16'h0);
            expect_v("rst_done", i, 4, 16'h0);
            expect_v("rst_wrap", i, 5, 16'h0);
        end
        chk();
        @(negedge c_clk) C_clr = 1'b0;

        // up run to DONE
        expect_v("idle_load", 0, 0, 16'h0000);
        cyc(0, 0, 0, 0);
        expect_v("go_run", 0, 3, 16'd1);
        cyc(0, 1, 0, 0);
        ticks(9998);
        expect_v("up_9998", 0, 0, 16'h9998);
        expect_v("up_9998_st", 0, 3, 16'd1);
        chk();
        expect_v("up_term", 0, 0, 16'h9999);
        expect_v("up_done", 0, 4, 16'd1);
        expect_v("up_done_st", 0, 3, 16'd3);
        expect_v("w1_no_done", 1, 3, 16'd1);
        cyc(1, 0, 0, 0);
        expect_v("done_hold", 0, 0, 16'h9999);
        expect_v("done_hold_st", 0, 3, 16'd3);
        expect_v("done_hold_dn", 0, 4, 16'd1);
        cyc(1, 1, 0, 0);

        // down borrow chain with lap
        dir = 1; use_load = 1; load = 16'h2000;
        expect_v("dn_load", 0, 0, 16'h2000);
        expect_v("dn_load_st", 0, 3, 16'd0);
        expect_v("dn_load_dn", 0, 4, 16'd0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        expect_v("dn_borrow", 0, 0, 16'h1999);
        expect_v("dn_lap", 0, 1, 16'h1999);
        expect_v("dn_lvld", 0, 2, 16'd1);
        cyc(1, 0, 1, 0);
        expect_v("rc_lvld", 0, 2, 16'd0);
        expect_v("rc_lap_hold", 0, 1, 16'h1999);
        expect_v("rc_count", 0, 0, 16'h2000);
        cyc(0, 0, 0, 1);

        // pause
        dir = 0; use_load = 0;
        expect_v("p_start", 0, 0, 16'h0000);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        ticks(5);
        expect_v("p_pause", 0, 3, 16'd2);
        cyc(0, 1, 0, 0);
        ticks(10);
        expect_v("p_frozen", 0, 0, 16'h0005);
        cyc(0, 1, 0, 0);
        ticks(3);
        expect_v("p_count", 0, 0, 16'h0008);
        expect_v("p_state", 0, 3, 16'd1);
        cyc(0, 0, 0, 0);

        // clamp of invalid load digits
        use_load = 1; load = 16'h00A5;
        expect_v("clamp", 0, 0, 16'h0095);
        cyc(0, 0, 0, 1);

        // wrap
        load = 16'h9998;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        expect_v("w_9999", 1, 0, 16'h9999);
        expect_v("w_nowrap", 1, 5, 16'd0);
        expect_v("w0_done", 0, 3, 16'd3);
        cyc(1, 0, 0, 0);
        expect_v("w_0000", 1, 0, 16'h0000);
        expect_v("w_pulse", 1, 5, 16'd1);
        expect_v("w_run", 1, 3, 16'd1);
        cyc(1, 0, 0, 0);
        expect_v("w_pulse_end", 1, 5, 16'd0);
        expect_v("w_hold", 1, 0, 16'h0000);
        cyc(0, 0, 0, 0);

        // go when start equals terminal
        load = 16'h9999;
        cyc(0, 0, 0, 1);
        expect_v("st_eq_term0", 0, 3, 16'd3);
        expect_v("st_eq_term1", 1, 3, 16'd1);
        cyc(0, 1, 0, 0);

        // simultaneous events
        load = 16'h0040;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        expect_v("s_lap", 0, 1, 16'h0041);
        cyc(1, 0, 1, 0);
        expect_v("s_rc_st", 0, 3, 16'd0);
        expect_v("s_rc_cnt", 0, 0, 16'h0040);
        expect_v("s_rc_lv", 0, 2, 16'd0);
        expect_v("s_rc_lap", 0, 1, 16'h0041);
        cyc(1, 1, 1, 1);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        expect_v("gt_cnt", 0, 0, 16'h0042);
        expect_v("gt_st", 0, 3, 16'd2);
        cyc(1, 1, 0, 0);
        expect_v("pgt_cnt", 0, 0, 16'h0042);
        expect_v("pgt_st", 0, 3, 16'd1);
        cyc(1, 1, 0, 0);

        // async reset mid-run
        load = 16'h1234;
        cyc(0, 0, 0, 1);
        expect_v("a_run", 0, 0, 16'h1234);
        cyc(0, 1, 0, 0);
        @(negedge c_clk);
        C_clr = 1'b1;
        #1;
        expect_v("a_count", 0, 0, 16'h0);
        expect_v("a_state", 0, 3, 16'd0);
        expect_v("a_lap", 0, 1, 16'h0);
        expect_v("a_lvld", 0, 2, 16'd0);
        expect_v("a_done", 0, 4, 16'd0);
        chk();
        #1 C_clr = 1'b0;
        expect_v("a_rel_cnt", 0, 0, 16'h1234);
        expect_v("a_rel_st", 0, 3, 16'd0);
        cyc(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_eval, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_core.md
# bcd_stopwatch_core

Parametrised N-digit BCD up/down stopwatch core with run/pause/done control, preload, lap capture and optional wrap-around. It sits between the tick-rate prescaler and the seven-segment scan logic, which consumes `count` and `lap_count` directly. It replaces the fixed 4-digit, 4-mode counter with one generic engine, chosen by `dir`/`use_load`.

## Interface
- `NDIG`, 4: number of BCD digits (1..8); count width is 4*NDIG.
- `WRAP`, 0: 0 = stop in DONE at the terminal value; 1 = wrap around and keep running.

- `c_clk`  in  1  system clock; all logic is rising-edge.
- `C_clr`  in  1  reset, asynchronous, active-high; clock `c_clk`.
- `tick`  in  1  count-enable strobe, one `c_clk` cycle wide.
- `go`  in  1  start/pause toggle pulse (already debounced, single cycle).
- `rst_cnt`  in  1  synchronous clear to the start value; returns to IDLE.
- `lap`  in  1  lap-capture pulse.
- `dir`  in  1  0 = count up, 1 = count down.
- `use_load`  in  1  1 = start from `load`; 0 = start from the default.
- `load`  in  4*NDIG  BCD preload value.
- `count`  out  4*NDIG  current BCD value.
- `lap_count`  out  4*NDIG  last captured value.
- `lap_valid`  out  1  `lap_count` holds a capture.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `done`  out  1  level, high in DONE.
- `wrap_p`  out  1  one-cycle pulse on each wrap (WRAP=1 only).

## Operation
- **Start value.** Default is 0 when up and all-9s when down. With `use_load=1` the start value is `load`, with each digit >9 clamped to 9.
- **Terminal value.** All-9s when up; 0 when down.
- **IDLE.** `count` reloads the start value every cycle. `dir_q` tracks `dir`. `tick` is ignored.
  - `go` → RUN, or → DONE if the start value equals the terminal value and WRAP=0.
- **RUN.** On `tick`, `count` steps ±1 in BCD with a ripple carry/borrow across all digits.
  - Up: 9→0 carries. Down: 0→9 borrows.
  - `go` → PAUSE.
  - With WRAP=0, a step that produces the terminal value → DONE on the same edge.
  - With WRAP=1, a step from the terminal value goes to 0 (up) or all-9s (down), pulses `wrap_p`, and stays in RUN.
- **PAUSE.** `tick` is ignored. `go` → RUN.
- **DONE.** `count` holds. `go` and `tick` are ignored.
- **Direction latch.** `dir_q` is frozen on leaving IDLE. `dir`, `use_load` and `load` are don't-care outside IDLE.
- **`rst_cnt`.** In any state it forces IDLE and loads the start value. It has priority over `go`, `tick` and `lap`.
- **`lap`.** In RUN or PAUSE, `lap_count` is set to the value `count` takes on this edge, i.e. the post-tick value when `tick` coincides, and `lap_valid` is set.
  - `lap` in IDLE or DONE is ignored.
  - `rst_cnt` clears `lap_valid`; `lap_count` is held.
- **`go` with `tick` in RUN.** The tick is applied first, then the state goes to PAUSE. If that tick reaches the terminal value, DONE wins.
- **`go` with `tick` in IDLE or PAUSE.** Only the state change happens; the tick is ignored.

## Timing
- **Reset values.** `C_clr` high sets:
  - `state`=IDLE, `count`=0, `dir_q`=0;
  - `lap_count`=0, `lap_valid`=0;
  - `done`=0, `wrap_p`=0.
  - The first clock after release loads the start value.
- **Reset mid-operation.** `C_clr` is asynchronous and takes effect immediately, including mid-RUN.
- **Latency.** Every input acts on the next rising edge, so outputs change one cycle after the strobe.
- **Output registration.** `done`, `state` and `wrap_p` are registered and align with the `count` update that caused them.
- **Tick spacing.** Back-to-back ticks (one per cycle) are legal; the ripple carry/borrow must close timing at NDIG=8.
- **Async `C_clr`.** There is no combinational path from `C_clr` to any output other than through register resets.

## Structure
- **Shared package** `stopwatch_pkg` holds:
  - the state encodings `ST_IDLE`/`ST_RUN`/`ST_PAUSE`/`ST_DONE`;
  - the BCD constants `BCD_NINE=4'h9` and `BCD_ZERO=4'h0`.
- **Sub-module** `bcd_digit`: one combinational digit step.
  - Inputs: `d[3:0]`, `en`, `dn`.
  - Outputs: `q[3:0]`, `co`, where `co` is the carry when up and the borrow when down.
  - Instantiate it NDIG times in a generate chain; digit k's `en` is digit k-1's `co`, and digit 0's `en` is `tick`.
- **Clamping** of invalid `load` digits is done in the top-level start-value logic.

## Test plan
- **Up run to DONE** (NDIG=4, WRAP=0, dir=0, use_load=0): `go`, then 9999 ticks → `count`=16'h9999, `done`=1, `state`=3. Further ticks and `go` leave everything unchanged.
- **Down borrow chain** (use_load=1, load=16'h2000, dir=1): `go`, one tick → 16'h1999. `lap` on that tick → `lap_count`=16'h1999, `lap_valid`=1.
- **Pause and clamp**: in RUN, 5 ticks, `go`, 10 ticks, `go`, 3 ticks → `count`=8 from 0.
  - Separately, load=16'h00A5 in IDLE → `count`=16'h0095.
- **Wrap** (WRAP=1, up, load=16'h9998): `go`, 2 ticks → 16'h9999 then 16'h0000. `wrap_p` is high for exactly one cycle on the second tick; `state` stays RUN.
- **Simultaneous events**: `rst_cnt`+`go`+`tick`+`lap` in RUN → IDLE, start value, `lap_valid`=0. `go`+`tick` in RUN at 16'h0041 → 16'h0042, PAUSE.
- **Async reset**: `C_clr` asserted mid-cycle during RUN at 16'h1234 → all outputs at their reset values before the next edge. After release, IDLE and start value on the first edge.
